// File: rtl/hamming_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : hamming_decoder_if
// Description : Byte-wide memory bus used by the Hamming(16,11) decoder.
//               A combinational read port (address out, data back in the same
//               cycle) and a single-byte write port.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals
//   raddr    : read address               (master -> slave)
//   DataOut  : read data, same-cycle      (slave  -> master)
//   WriteEn  : write strobe, one byte/cyc (master -> slave)
//   waddr    : write address              (master -> slave)
//   DataIn   : write data                 (master -> slave)
// ============================================================================
interface hamming_decoder_if #(
  parameter int W = 8
) ();
  logic [W-1:0] raddr;
  logic [W-1:0] DataOut;
  logic         WriteEn;
  logic [W-1:0] waddr;
  logic [W-1:0] DataIn;

  modport master (
    output raddr,
    input  DataOut,
    output WriteEn,
    output waddr,
    output DataIn
  );

  modport slave (
    input  raddr,
    output DataOut,
    input  WriteEn,
    input  waddr,
    input  DataIn
  );
endinterface
`default_nettype wire

// File: rtl/hamming_decoder.sv
`default_nettype none
// ============================================================================
// Module      : hamming_decode_core
// Description : Purely combinational Hamming(16,11)+overall-parity decoder.
//               Word layout: c[15:9]=d10..d4, c8=p8, c[7:5]=d3..d1, c4=p4,
//               c3=d0, c2=p2, c1=p1, c0=p0 (even parity over all 16 bits).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   code  : received 16-bit code word
//   data  : 11-bit payload, single errors corrected
//   flags : 00 clean, 01 single error corrected, 10 double error detected
// ============================================================================
module hamming_decode_core (
  input  logic [15:0] code,
  output logic [10:0] data,
  output logic [1:0]  flags
);
  // Syndrome bit j is the parity of every position whose index has bit j set;
  // that equals the XOR of the indices of all set bits.
  localparam logic [15:0] c_mask_s0 = 16'hAAAA;
  localparam logic [15:0] c_mask_s1 = 16'hCCCC;
  localparam logic [15:0] c_mask_s2 = 16'hF0F0;
  localparam logic [15:0] c_mask_s3 = 16'hFF00;

  logic [3:0] syndrome;
  logic       parity;

  always_comb begin
    syndrome[0] = ^(code & c_mask_s0);
    syndrome[1] = ^(code & c_mask_s1);
    syndrome[2] = ^(code & c_mask_s2);
    syndrome[3] = ^(code & c_mask_s3);
    parity      = ^code;
  end

  // A data bit is flipped only when overall parity fails and the syndrome
  // points at its position; a double error (parity good, syndrome nonzero)
  // leaves the payload untouched.
  for (genvar j = 0; j < 11; j++) begin : g_data
    localparam int c_pos = (j == 0) ? 3 : (j < 4) ? j + 4 : j + 5;
    assign data[j] = code[c_pos] ^ (parity && (syndrome == 4'(c_pos)));
  end

  always_comb begin
    flags = 2'b00;
    if (parity) begin
      flags = 2'b01;
    end else if (syndrome != 4'd0) begin
      flags = 2'b10;
    end
  end
endmodule

// ============================================================================
// Module      : hamming_decoder
// Description : Walks NUM_WORDS encoded words (stored low byte first from
//               SRC_BASE), decodes each one, and writes payload plus status
//               (low byte = d[7:0], high byte = {flags,3'b000,d[10:8]}) from
//               DST_BASE. Five cycles per word; done holds until Init/reset.
//               Assumes W >= 8 (one encoded byte per memory location).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        : clock, all state on rising edge
//   reset      : asynchronous active-high reset
//   Init       : synchronous start/hold; pass starts on first edge after fall
//   mem        : memory bus (master side)
//   single_cnt : words with a corrected single error this pass
//   double_cnt : words with a detected double error this pass
//   done       : pass complete
// ============================================================================
module hamming_decoder #(
  parameter int W         = 8,
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Init,
  hamming_decoder_if.master     mem,
  output logic [W-1:0]          single_cnt,
  output logic [W-1:0]          double_cnt,
  output logic                  done
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_DEC   = 3'd3,
    S_WR_LO = 3'd4,
    S_WR_HI = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [5:0]   c_last_idx = 6'(NUM_WORDS - 1);
  localparam logic [W-1:0] c_src_base = W'(SRC_BASE);
  localparam logic [W-1:0] c_dst_base = W'(DST_BASE);
  localparam logic [W-1:0] c_one      = W'(1);

  state_t       state_q,  state_d;
  logic [5:0]   idx_q,    idx_d;
  logic [15:0]  code_q,   code_d;
  logic [10:0]  data_q,   data_d;
  logic [1:0]   flags_q,  flags_d;
  logic [W-1:0] single_q, single_d;
  logic [W-1:0] double_q, double_d;

  logic [W-1:0] word_ofs;
  logic [W-1:0] src_addr;
  logic [W-1:0] dst_addr;
  logic [10:0]  dec_data;
  logic [1:0]   dec_flags;

  logic [W-1:0] raddr_c;
  logic [W-1:0] waddr_c;
  logic [W-1:0] wdata_c;
  logic         wen_c;

  hamming_decode_core u_core (
    .code  (code_q),
    .data  (dec_data),
    .flags (dec_flags)
  );

  // Each word occupies two bytes; address arithmetic wraps at 2^W.
  assign word_ofs = W'({idx_q, 1'b0});
  assign src_addr = c_src_base + word_ofs;
  assign dst_addr = c_dst_base + word_ofs;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    code_d   = code_q;
    data_d   = data_q;
    flags_d  = flags_q;
    single_d = single_q;
    double_d = double_q;
    raddr_c  = '0;
    waddr_c  = '0;
    wdata_c  = '0;
    wen_c    = 1'b0;

    // Init overrides the whole FSM, and the bus is silenced in the same
    // cycle so an abort landing in WR_LO/WR_HI cannot strobe a write.
    if (Init) begin
      state_d  = S_IDLE;
      idx_d    = '0;
      code_d   = '0;
      data_d   = '0;
      flags_d  = '0;
      single_d = '0;
      double_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_RD_LO;
        end
        S_RD_LO: begin
          raddr_c     = src_addr;
          code_d[7:0] = mem.DataOut[7:0];
          state_d     = S_RD_HI;
        end
        S_RD_HI: begin
          raddr_c      = src_addr + c_one;
          code_d[15:8] = mem.DataOut[7:0];
          state_d      = S_DEC;
        end
        S_DEC: begin
          data_d  = dec_data;
          flags_d = dec_flags;
          if (dec_flags == 2'b01) begin
            single_d = single_q + c_one;
          end
          if (dec_flags == 2'b10) begin
            double_d = double_q + c_one;
          end
          state_d = S_WR_LO;
        end
        S_WR_LO: begin
          wen_c   = 1'b1;
          waddr_c = dst_addr;
          wdata_c = W'(data_q[7:0]);
          state_d = S_WR_HI;
        end
        S_WR_HI: begin
          wen_c   = 1'b1;
          waddr_c = dst_addr + c_one;
          wdata_c = W'({flags_q, 3'b000, data_q[10:8]});
          if (idx_q == c_last_idx) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = S_RD_LO;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      code_q   <= '0;
      data_q   <= '0;
      flags_q  <= '0;
      single_q <= '0;
      double_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      code_q   <= code_d;
      data_q   <= data_d;
      flags_q  <= flags_d;
      single_q <= single_d;
      double_q <= double_d;
    end
  end

  assign mem.raddr   = raddr_c;
  assign mem.waddr   = waddr_c;
  assign mem.DataIn  = wdata_c;
  assign mem.WriteEn = wen_c;

  assign single_cnt = single_q;
  assign double_cnt = double_q;
  assign done       = (state_q == S_DONE) && !Init;
endmodule
`default_nettype wire

// File: tb/tb_hamming_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_hamming_decoder
// Description : Self-checking bench for hamming_decoder. A one-word instance
//               runs a fixed vector table; a fifteen-word instance runs
//               randomized passes, an abort and an async reset; a standalone
//               decode core is swept over all 2^16 code words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_decoder;
  localparam int W   = 8;
  localparam int NW  = 15;
  localparam int SRC = 30;
  localparam int DST = 0;
  localparam int NV  = 8;

  typedef struct {
    logic [15:0] code;
    logic [7:0]  lo;
    logic [7:0]  hi;
    int          sgl;
    int          dbl;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic init_a, init_b;
  logic [W-1:0] single_a, double_a, single_b, double_b;
  logic done_a, done_b;

  logic       tb_we, tb_sel;
  logic [7:0] tb_addr, tb_data;
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  int         wr_cnt_a = 0;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_lo [NW];
  logic [7:0] exp_hi [NW];
  int         exp_s, exp_d;
  vec_t       vecs [NV];

  logic [15:0] sw_code;
  logic [10:0] sw_data;
  logic [1:0]  sw_flags;

  always #5 clk = ~clk;

  hamming_decoder_if #(.W(W)) bus_a ();
  hamming_decoder_if #(.W(W)) bus_b ();

  hamming_decoder #(.W(W), .NUM_WORDS(NW), .SRC_BASE(SRC), .DST_BASE(DST)) dut_a (
    .clk(clk), .reset(reset), .Init(init_a), .mem(bus_a),
    .single_cnt(single_a), .double_cnt(double_a), .done(done_a)
  );

  hamming_decoder #(.W(W), .NUM_WORDS(1), .SRC_BASE(SRC), .DST_BASE(DST)) dut_b (
    .clk(clk), .reset(reset), .Init(init_b), .mem(bus_b),
    .single_cnt(single_b), .double_cnt(double_b), .done(done_b)
  );

  hamming_decode_core u_sweep (.code(sw_code), .data(sw_data), .flags(sw_flags));

  assign bus_a.DataOut = mem_a[bus_a.raddr];
  assign bus_b.DataOut = mem_b[bus_b.raddr];

  always @(posedge clk) begin
    if (bus_a.WriteEn) begin
      mem_a[bus_a.waddr] <= bus_a.DataIn;
      wr_cnt_a <= wr_cnt_a + 1;
    end else if (tb_we && !tb_sel) begin
      mem_a[tb_addr] <= tb_data;
    end
    if (bus_b.WriteEn) begin
      mem_b[bus_b.waddr] <= bus_b.DataIn;
    end else if (tb_we && tb_sel) begin
      mem_b[tb_addr] <= tb_data;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [10:0] extract(input logic [15:0] c);
    int dpos [11];
    logic [10:0] d;
    dpos = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    for (int j = 0; j < 11; j++) d[j] = c[dpos[j]];
    return d;
  endfunction

  function automatic logic [15:0] encode(input logic [10:0] d);
    int dpos [11];
    logic [15:0] c;
    int s;
    dpos = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    c = '0;
    s = 0;
    for (int j = 0; j < 11; j++) begin
      if (d[j]) begin
        c[dpos[j]] = 1'b1;
        s = s ^ dpos[j];
      end
    end
    for (int b = 0; b < 4; b++) if (s[b]) c[1 << b] = 1'b1;
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic logic [12:0] model_decode(input logic [15:0] c);
    int s, ones;
    logic [15:0] f;
    logic [1:0] fl;
    s = 0;
    ones = 0;
    for (int k = 0; k < 16; k++) begin
      if (c[k]) begin
        ones++;
        s = s ^ k;
      end
    end
    f = c;
    fl = 2'b00;
    if (ones % 2 == 1) begin
      fl = 2'b01;
      f[s] = ~f[s];
    end else if (s != 0) begin
      fl = 2'b10;
    end
    return {fl, extract(f)};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic poke(input bit sel, input logic [7:0] addr, input logic [7:0] data);
    tb_sel  = sel;
    tb_addr = addr;
    tb_data = data;
    tb_we   = 1'b1;
    @(negedge clk);
    tb_we   = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int limit, output int cyc);
    cyc = 0;
    while (((sel ? done_b : done_a) !== 1'b1) && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic build_pass(input bit force_single0);
    logic [10:0] d;
    logic [15:0] c;
    logic [1:0]  fl;
    int nerr, p1, p2;
    exp_s = 0;
    exp_d = 0;
    for (int i = 0; i < NW; i++) begin
      d = 11'($urandom_range(0, 2047));
      c = encode(d);
      nerr = (i == 0 && force_single0) ? 1 : (i % 3);
      p1 = $urandom_range(0, 15);
      p2 = (p1 + $urandom_range(1, 15)) % 16;
      if (nerr >= 1) c[p1] = ~c[p1];
      if (nerr == 2) c[p2] = ~c[p2];
      case (nerr)
        0: fl = 2'b00;
        1: begin fl = 2'b01; exp_s++; end
        default: begin fl = 2'b10; d = extract(c); exp_d++; end
      endcase
      exp_lo[i] = d[7:0];
      exp_hi[i] = {fl, 3'b000, d[10:8]};
      poke(1'b0, 8'(SRC + 2 * i), c[7:0]);
      poke(1'b0, 8'(SRC + 2 * i + 1), c[15:8]);
      poke(1'b0, 8'(DST + 2 * i), 8'hEE);
      poke(1'b0, 8'(DST + 2 * i + 1), 8'hEE);
    end
  endtask

  task automatic check_pass(input string tag);
    for (int i = 0; i < NW; i++) begin
      check($sformatf("%s lo[%0d]", tag, i), mem_a[8'(DST + 2 * i)], exp_lo[i]);
      check($sformatf("%s hi[%0d]", tag, i), mem_a[8'(DST + 2 * i + 1)], exp_hi[i]);
    end
    check({tag, " single_cnt"}, single_a, exp_s);
    check({tag, " double_cnt"}, double_a, exp_d);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc, w0, bad, first;

    vecs[0] = '{16'hFFFF, 8'hFF, 8'h07, 0, 0};
    vecs[1] = '{16'hFFF7, 8'hFF, 8'h47, 1, 0};
    vecs[2] = '{16'hFFD7, 8'hFC, 8'h87, 0, 1};
    vecs[3] = '{16'hFFFE, 8'hFF, 8'h47, 1, 0};
    vecs[4] = '{16'h0000, 8'h00, 8'h00, 0, 0};
    vecs[5] = '{16'h0001, 8'h00, 8'h40, 1, 0};
    vecs[6] = '{16'h8000, 8'h00, 8'h40, 1, 0};
    vecs[7] = '{16'h0003, 8'h00, 8'h80, 0, 1};

    reset = 1'b1; init_a = 1'b1; init_b = 1'b1;
    tb_we = 1'b0; tb_sel = 1'b0; tb_addr = '0; tb_data = '0; sw_code = '0;
    repeat (2) @(negedge clk);
    check("reset raddr_a", bus_a.raddr, 0);
    check("reset waddr_a", bus_a.waddr, 0);
    check("reset wen_a", bus_a.WriteEn, 0);
    check("reset din_a", bus_a.DataIn, 0);
    check("reset single_a", single_a, 0);
    check("reset double_a", double_a, 0);
    check("reset done_a", done_a, 0);
    check("reset done_b", done_b, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single-word vector table.
    for (int v = 0; v < NV; v++) begin
      poke(1'b1, 8'(SRC), vecs[v].code[7:0]);
      poke(1'b1, 8'(SRC + 1), vecs[v].code[15:8]);
      poke(1'b1, 8'(DST), 8'h5A);
      poke(1'b1, 8'(DST + 1), 8'h5A);
      check($sformatf("vec%0d idle done", v), done_b, 0);
      init_b = 1'b0;
      wait_done(1'b1, 20, cyc);
      check($sformatf("vec%0d latency", v), cyc, 6);
      check($sformatf("vec%0d lo", v), mem_b[8'(DST)], vecs[v].lo);
      check($sformatf("vec%0d hi", v), mem_b[8'(DST + 1)], vecs[v].hi);
      check($sformatf("vec%0d single", v), single_b, vecs[v].sgl);
      check($sformatf("vec%0d double", v), double_b, vecs[v].dbl);
      init_b = 1'b1;
      @(negedge clk);
    end

    // Full randomized pass.
    build_pass(1'b0);
    w0 = wr_cnt_a;
    init_a = 1'b0;
    wait_done(1'b0, 200, cyc);
    check("pass1 latency", cyc, 5 * NW + 1);
    check_pass("pass1");
    check("pass1 writes", wr_cnt_a - w0, 2 * NW);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("done hold", done_a, 1);
      check("done hold wen", bus_a.WriteEn, 0);
    end
    init_a = 1'b1;
    #1;
    check("done drops on Init", done_a, 0);
    @(negedge clk);
    check("Init clears single", single_a, 0);
    check("Init clears double", double_a, 0);

    // Abort in cycle 7 (DEC of word 1), then restart.
    build_pass(1'b1);
    init_a = 1'b0;
    repeat (8) @(negedge clk);
    check("abort pre single", single_a, 1);
    init_a = 1'b1;
    #1;
    check("abort wen now", bus_a.WriteEn, 0);
    check("abort done now", done_a, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort wen", bus_a.WriteEn, 0);
      check("abort raddr", bus_a.raddr, 0);
      check("abort single", single_a, 0);
      check("abort double", double_a, 0);
    end
    check("abort no word1 lo", mem_a[8'(DST + 2)], 8'hEE);
    check("abort no word1 hi", mem_a[8'(DST + 3)], 8'hEE);
    w0 = wr_cnt_a;
    init_a = 1'b0;
    wait_done(1'b0, 200, cyc);
    check("restart latency", cyc, 5 * NW + 1);
    check_pass("restart");
    check("restart writes", wr_cnt_a - w0, 2 * NW);

    // Async reset during RD_HI of word 1.
    init_a = 1'b1;
    @(negedge clk);
    init_a = 1'b0;
    repeat (7) @(negedge clk);
    check("rd_hi raddr", bus_a.raddr, SRC + 3);
    check("rd_hi single", single_a, 1);
    #2 reset = 1'b1;
    #1;
    check("async raddr", bus_a.raddr, 0);
    check("async wen", bus_a.WriteEn, 0);
    check("async single", single_a, 0);
    check("async done", done_a, 0);
    init_a = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Exhaustive decode sweep.
    bad = 0;
    first = 0;
    for (int p = 0; p < 65536; p++) begin
      sw_code = 16'(p);
      #1;
      if ({sw_flags, sw_data} !== model_decode(16'(p))) begin
        if (bad == 0) first = p;
        bad++;
      end
    end
    check($sformatf("sweep bad patterns (first 0x%0h)", first), bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/hamming_decoder.md
Name: hamming_decoder

Overview:
- Downstream companion of the Hamming(16,11) encoder stage.
- Walks NUM_WORDS encoded 16-bit words stored as byte pairs in data memory and recomputes the syndrome and overall parity.
- Corrects single-bit errors and flags double-bit errors.
- Writes each decoded 11-bit payload plus a 2-bit status back to memory, and raises done when the pass is complete.

Parameters:
- W, 8, memory data width and address width (bits).
- NUM_WORDS, 15, number of encoded words processed per pass (1..63).
- SRC_BASE, 30, byte address of the low byte of encoded word 0.
- DST_BASE, 0, byte address of the low byte of decoded word 0.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- Init  input  1  synchronous start/hold; while high the block idles and clears; the pass starts on the first clk edge after it falls.
- raddr  output  W  memory read address.
- DataOut  input  W  memory read data; combinational, valid in the same cycle as raddr.
- WriteEn  output  1  memory write strobe, one byte per cycle.
- waddr  output  W  memory write address.
- DataIn  output  W  memory write data.
- single_cnt  output  W  count of words with corrected single errors this pass.
- double_cnt  output  W  count of words with detected double errors this pass.
- done  output  1  high in DONE; held until Init or reset.

Behaviour:
- Reset (async) or Init high:
  - state=IDLE, word index i=0, temp word=0.
  - raddr=waddr=DataIn=0, WriteEn=0, counters=0, done=0.
- Encoded bit layout of word c[15:0]:
  - c[15:9]=d10..d4, c8=p8, c[7:5]=d3..d1, c4=p4, c3=d0, c2=p2, c1=p1.
  - c0=p0, even parity over all 16 bits.
- State machine, one state per cycle; word i uses addresses S=SRC_BASE+2i and D=DST_BASE+2i, all address math mod 2^W.
  - RD_LO: raddr=S; capture DataOut into c[7:0].
  - RD_HI: raddr=S+1; capture DataOut into c[15:8].
  - DEC: compute the syndrome, parity, flags and corrected data; register them.
    - s[3:0] = XOR of the indices k (1..15) with c[k]=1.
    - P = ^c[15:0].
    - P=0, s=0: flags=00, data unchanged.
    - P=1 (any s): flags=01; invert bit c[s] (s=0 means p0, data unchanged); single_cnt+1.
    - P=0, s≠0: flags=10, data passed uncorrected, double_cnt+1.
  - WR_LO: WriteEn=1, waddr=D, DataIn=d[7:0].
  - WR_HI:
    - WriteEn=1, waddr=D+1, DataIn={flags[1:0],3'b000,d[10:8]}.
    - If i==NUM_WORDS-1 go to DONE, else i+1 and go to RD_LO.
  - IDLE → RD_LO on the first edge with Init low.
  - DONE: done=1, WriteEn=0; stays until Init or reset.
- Timing and output rules:
  - Latency is 5 cycles per word; done rises 5*NUM_WORDS cycles after the first RD_LO cycle.
  - WriteEn is never high outside WR_LO/WR_HI. raddr/waddr/DataIn are 0 when not used.
  - Counters increment in DEC only. They do not wrap, since NUM_WORDS ≤ 63.
- Boundary conditions:
  - Init asserted mid-pass aborts on the next edge to IDLE with everything cleared; no partial write is completed.
  - Reset mid-pass takes effect immediately.
  - Source and destination ranges that overlap are not protected: each word's reads finish before its writes.
  - The decoder itself must be identical for all 2^16 inputs; the bench checks it exhaustively against a reference model.

Test Plan:
- Clean word: mem[30]=0xFF, mem[31]=0xFF (data 0x7FF), NUM_WORDS=1 → mem[0]=0xFF, mem[1]=0x07, counters 0/0, done 6 cycles after Init falls.
- Single data-bit error: encoded 0xFFF7 (bit3 flipped) → s=3, mem[0]=0xFF, mem[1]=0x47, single_cnt=1.
- Double error: encoded 0xFFD7 (bits 3, 5 flipped) → P=0, s=6, mem[0]=0xFC, mem[1]=0x87, double_cnt=1.
- p0-only error: encoded 0xFFFE → mem[0]=0xFF, mem[1]=0x47. Encoded 0x0000 → 0x00/0x00.
- Full pass of 15 words with a mix of clean, single, and double errors → all 30 destination bytes match the model, counters match, and done holds until Init.
- Abort and exhaustive check:
  - Raise Init at cycle 7 → WriteEn stays 0 and counters clear; after restart, results are identical to an uninterrupted run.
  - Async reset mid-RD_HI clears outputs in the same cycle.
  - Exhaustive sweep of all 65536 patterns through DEC against the model.
